// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ISA constants and decoded-instruction type
package cpu_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int IMM_W    = 16;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LUI  = 4'd7;

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [IMM_W-1:0]  imm;
        logic              use_rs1;
        logic              use_rs2;
        logic              we;
        logic              illegal;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction-word to decoded-struct mapping
// Ports: instr (32-bit word in), dec (decoded fields and usage flags out).
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output dec_t            dec
);

    always_comb begin
        dec         = '0;
        dec.op      = instr[OP_MSB:OP_LSB];
        dec.rd      = instr[RD_MSB:RD_LSB];
        dec.rs1     = instr[RS1_MSB:RS1_LSB];
        dec.rs2     = instr[RS2_MSB:RS2_LSB];
        dec.imm     = instr[IMM_MSB:IMM_LSB];
        case (instr[OP_MSB:OP_LSB])
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.we      = 1'b1;
            end
            OP_ADDI: begin
                dec.use_rs1 = 1'b1;
                dec.we      = 1'b1;
            end
            OP_LUI: begin
                dec.we      = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage with hold register and busy scoreboard
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/in_instr upstream
// handshake; out_valid/out_ready and decoded out_* fields downstream;
// wb_valid/wb_rd writeback release; flush drops the held instruction;
// busy scoreboard and saturating stall_cnt are observable.
module decode_issue
    import cpu_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_op,
    output logic [3:0]             out_rd,
    output logic [3:0]             out_rs1,
    output logic [3:0]             out_rs2,
    output logic [15:0]            out_imm,
    output logic                   out_we,
    output logic                   out_illegal,
    input  logic                   wb_valid,
    input  logic [3:0]             wb_rd,
    input  logic                   flush,
    output logic [15:0]            busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    dec_t                   dec;
    dec_t                   hold_q, hold_d;
    logic                   full_q, full_d;
    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_REGS-1:0]    wb_mask;
    logic [NUM_REGS-1:0]    eff_busy;
    logic                   hazard;
    logic                   issue;
    logic                   load;

    instr_decoder u_dec (
        .instr (in_instr),
        .dec   (dec)
    );

    always_comb begin
        wb_mask = wb_valid ? (16'b1 << wb_rd) : 16'b0;
        // A writeback landing this cycle already counts as released; R0 never busy.
        eff_busy = busy_q & ~wb_mask & 16'hFFFE;

        hazard = (hold_q.use_rs1 && eff_busy[hold_q.rs1]) ||
                 (hold_q.use_rs2 && eff_busy[hold_q.rs2]) ||
                 (hold_q.we      && eff_busy[hold_q.rd]);

        out_valid = full_q && !hazard;
        // flush wins over issue: the held instruction is discarded, not sent.
        issue     = out_valid && out_ready && !flush;
        in_ready  = !flush && (!full_q || (out_valid && out_ready));
        load      = in_valid && in_ready;

        hold_d = hold_q;
        full_d = full_q;
        if (load) begin
            hold_d = dec;
            full_d = 1'b1;
        end else if (issue || flush) begin
            full_d = 1'b0;
        end

        // Clear before set so a same-cycle issue to wb_rd leaves the bit set.
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue && hold_q.we && (hold_q.rd != '0)) begin
            busy_d[hold_q.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (full_q && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= '0;
            full_q      <= 1'b0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            hold_q      <= hold_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        out_op      = hold_q.op;
        out_rd      = hold_q.rd;
        out_rs1     = hold_q.rs1;
        out_rs2     = hold_q.rs2;
        out_imm     = hold_q.imm;
        out_we      = hold_q.we;
        out_illegal = hold_q.illegal;
        busy        = busy_q;
        stall_cnt   = stall_cnt_q;
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - self-checking bench for decode_issue
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op, out_rd, out_rs1, out_rs2;
    logic [15:0] out_imm;
    logic        out_we, out_illegal;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [15:0] busy;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    decode_issue #(.STALL_CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_we      (out_we),
        .out_illegal (out_illegal),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: architectural state only
    bit          m_known = 0;
    bit          m_full  = 0;
    logic [31:0] m_word  = '0;
    logic [15:0] m_busy  = '0;
    int          m_stall = 0;

    function automatic bit reads_rs1(input int op);
        return (op >= 1 && op <= 6);
    endfunction
    function automatic bit reads_rs2(input int op);
        return (op >= 1 && op <= 5);
    endfunction
    function automatic bit writes_rd(input int op);
        return (op >= 1 && op <= 7);
    endfunction

    function automatic bit pending(input int r);
        if (r == 0) return 0;
        if (wb_valid && int'(wb_rd) == r) return 0;
        return m_busy[r];
    endfunction

    always @(negedge clk) begin
        int  op, rd, rs1, rs2;
        bit  haz, e_ov, e_ir, iss;
        op  = int'(m_word[31:28]);
        rd  = int'(m_word[27:24]);
        rs1 = int'(m_word[23:20]);
        rs2 = int'(m_word[19:16]);
        haz = (reads_rs1(op) && pending(rs1)) || (reads_rs2(op) && pending(rs2)) ||
              (writes_rd(op) && pending(rd));
        e_ov = m_full && !haz;
        e_ir = !flush && (!m_full || (e_ov && out_ready));
        if (m_known) begin
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("in_ready", 32'(in_ready), 32'(e_ir));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("out_fields", {out_op, out_rd, out_rs1, out_rs2, out_imm}, m_word);
            chk("out_we", 32'(out_we), 32'(writes_rd(op)));
            chk("out_illegal", 32'(out_illegal), 32'(op >= 8));
        end
        if (!rst_n) begin
            m_known = 1;
            m_full  = 0;
            m_word  = '0;
            m_busy  = '0;
            m_stall = 0;
        end else if (m_known) begin
            iss = e_ov && out_ready && !flush;
            if (m_full && haz && m_stall < 65535) m_stall++;
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (iss && writes_rd(op) && rd != 0) m_busy[rd] = 1'b1;
            if (in_valid && e_ir) begin
                m_full = 1;
                m_word = in_instr;
            end else if (iss || flush) begin
                m_full = 0;
            end
        end
    end

    task automatic cyc(input logic rn, input logic iv, input logic [31:0] ins,
                       input logic ordy, input logic wbv, input logic [3:0] wbr,
                       input logic fl);
        @(posedge clk);
        #1;
        rst_n     = rn;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        wb_valid  = wbv;
        wb_rd     = wbr;
        flush     = fl;
        #1;
    endtask

    initial begin
        // Reset then single ADD R1,R2,R3
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_reset_in_ready", 32'(in_ready), 1);
        chk("lit_reset_busy", 32'(busy), 0);
        chk("lit_reset_out_valid", 32'(out_valid), 0);
        cyc(1, 1, 32'h1123_0000, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_add_valid", 32'(out_valid), 1);
        chk("lit_add_regs", {out_rd, out_rs1, out_rs2}, 32'h123);
        chk("lit_add_we", 32'(out_we), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_add_busy", 32'(busy), 32'h0002);

        // RAW stall on R1, released by same-cycle writeback
        cyc(1, 1, 32'h1415_0000, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_raw_stall0", 32'(out_valid), 0);
        chk("lit_raw_cnt0", 32'(stall_cnt), 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_raw_cnt1", 32'(stall_cnt), 1);
        cyc(1, 0, 0, 1, 1, 4'd1, 0);
        chk("lit_raw_release", 32'(out_valid), 1);
        chk("lit_raw_cnt2", 32'(stall_cnt), 2);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_raw_busy", 32'(busy), 32'h0010);

        // Same-cycle issue and writeback to R7
        cyc(1, 1, 32'h7700_0005, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 4'd7, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_setclr_busy", 32'(busy), 32'h0090);

        // Illegal opcode 0xA
        cyc(1, 1, 32'hA123_0000, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_illegal_flag", 32'(out_illegal), 1);
        chk("lit_illegal_we", 32'(out_we), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_illegal_busy", 32'(busy), 32'h0090);

        // Flush while stalled on R7
        cyc(1, 1, 32'h1870_0000, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 1);
        chk("lit_flush_in_ready", 32'(in_ready), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_flush_busy", 32'(busy), 32'h0090);
        chk("lit_flush_valid", 32'(out_valid), 0);

        // R0 writes and reads never hazard
        cyc(1, 1, 32'h6000_0005, 1, 0, 0, 0);
        cyc(1, 1, 32'h1600_0000, 1, 0, 0, 0);
        chk("lit_r0_valid1", 32'(out_valid), 1);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_r0_valid2", 32'(out_valid), 1);
        chk("lit_r0_busy", 32'(busy), 32'h0090);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_r6_busy", 32'(busy), 32'h00D0);

        // Back-to-back independent instructions
        cyc(1, 1, 32'h69D0_0001, 1, 0, 0, 0);
        chk("lit_b2b_ready0", 32'(in_ready), 1);
        cyc(1, 1, 32'h6AD0_0002, 1, 0, 0, 0);
        chk("lit_b2b_valid1", 32'(out_valid), 1);
        chk("lit_b2b_ready1", 32'(in_ready), 1);
        cyc(1, 1, 32'h6BE0_0003, 1, 0, 0, 0);
        chk("lit_b2b_valid2", 32'(out_valid), 1);
        chk("lit_b2b_ready2", 32'(in_ready), 1);
        cyc(1, 1, 32'h6CE0_0004, 1, 0, 0, 0);
        chk("lit_b2b_valid3", 32'(out_valid), 1);
        chk("lit_b2b_ready3", 32'(in_ready), 1);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_b2b_valid4", 32'(out_valid), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_b2b_busy", 32'(busy), 32'h1ED0);

        // Reset in the middle of a stall on R9
        cyc(1, 1, 32'h1190_0000, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("lit_rst_stall", 32'(out_valid), 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_busy", 32'(busy), 0);
        chk("lit_rst_valid", 32'(out_valid), 0);
        chk("lit_rst_rd", 32'(out_rd), 0);
        chk("lit_rst_cnt", 32'(stall_cnt), 0);
        chk("lit_rst_ready", 32'(in_ready), 1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [3:0]  op, r;
            logic [31:0] w;
            logic        wv, rn;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15));
            w  = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 16'($urandom)};
            r  = 4'($urandom_range(1, 7));
            wv = ($urandom_range(0, 2) != 0) && (m_busy[r] || $urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 299) != 0);
            cyc(rn, 1'($urandom_range(0, 9) < 7), w, 1'($urandom_range(0, 9) < 7),
                wv, r, 1'($urandom_range(0, 29) == 0));
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
